// File: rtl/wave_phase_monitor.sv
// wave_phase_monitor: per-phase period/high-time meter and p1->p2->p3 order checker.
// Ports: clk, rst (sync, active-high); p1..p3 phase inputs;
//   period_len/high_len (3*CW, field i at [i*CW +: CW], i=0 is p1);
//   meas_valid[2:0] result strobes; order_err pulse; err_sticky; stall pulse.
// Optional: define WAVE_PHASE_MONITOR_TIMEOUT_EN for the TIMEOUT stall watchdog.
module wave_phase_monitor #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p1,
  input  logic            p2,
  input  logic            p3,
  output logic [3*CW-1:0] period_len,
  output logic [3*CW-1:0] high_len,
  output logic [2:0]      meas_valid,
  output logic            order_err,
  output logic            err_sticky,
  output logic            stall
);

  typedef enum logic [1:0] {
    IDLE,
    EXP1,
    EXP2,
    EXP3
  } state_e;

  localparam logic [CW-1:0] SAT = '1;

  logic [2:0]      p;
  logic [2:0]      rise;
  logic [2:0]      prev_q;
  logic [2:0]      armed_q;
  logic [CW-1:0]   per_q [3];
  logic [CW-1:0]   hi_q  [3];
  logic [3*CW-1:0] period_q;
  logic [3*CW-1:0] high_q;
  logic [2:0]      mv_q;

  state_e state_q, state_d;
  logic   order_err_q, order_err_d;
  logic   err_q;
  logic   stall_set;
  logic   multi;
  logic [2:0] exp_m;

  assign p    = {p3, p2, p1};
  assign rise = p & ~prev_q;
  // More than one bit set in rise.
  assign multi = (rise & (rise - 3'd1)) != 3'd0;

  // Counters and measurement capture. The first rise after reset
  // only arms the channel since its counters hold no full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      armed_q  <= '0;
      mv_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        per_q[i] <= '0;
        hi_q[i]  <= '0;
      end
    end else begin
      prev_q <= p;
      mv_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        if (rise[i]) begin
          per_q[i]   <= CW'(1);
          hi_q[i]    <= CW'(1);
          armed_q[i] <= 1'b1;
          if (armed_q[i]) begin
            period_q[i*CW +: CW] <= per_q[i];
            high_q[i*CW +: CW]   <= hi_q[i];
            mv_q[i]              <= 1'b1;
          end
        end else begin
          if (per_q[i] != SAT) begin
            per_q[i] <= per_q[i] + 1'b1;
          end
          if (p[i] && (hi_q[i] != SAT)) begin
            hi_q[i] <= hi_q[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef WAVE_PHASE_MONITOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_TO = TW'(TIMEOUT);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          stall_q;
`endif

  always_comb begin
    state_d     = state_q;
    order_err_d = 1'b0;
    exp_m       = 3'b000;
`ifdef WAVE_PHASE_MONITOR_TIMEOUT_EN
    stall_set   = 1'b0;
`endif
    unique case (state_q)
      EXP1:    exp_m = 3'b001;
      EXP2:    exp_m = 3'b010;
      EXP3:    exp_m = 3'b100;
      default: exp_m = 3'b000;
    endcase
    if (multi) begin
      order_err_d = 1'b1;
      state_d     = IDLE;
    end else if (|rise) begin
      // A lone rise always resyncs to the phase after it.
      order_err_d = (state_q != IDLE) && (rise != exp_m);
      unique case (1'b1)
        rise[0]: state_d = EXP2;
        rise[1]: state_d = EXP3;
        rise[2]: state_d = EXP1;
        default: state_d = state_q;
      endcase
    end
`ifdef WAVE_PHASE_MONITOR_TIMEOUT_EN
    else if ((state_q != IDLE) && (tmr_q == TMR_TO)) begin
      stall_set = 1'b1;
      state_d   = IDLE;
    end
`endif
  end

`ifdef WAVE_PHASE_MONITOR_TIMEOUT_EN
  always_comb begin
    tmr_d = tmr_q;
    if ((state_q == IDLE) || (|rise) || stall_set) begin
      tmr_d = '0;
    end else if (tmr_q != '1) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      stall_q <= stall_set;
    end
  end

  assign stall = stall_q;
`else
  assign stall_set = 1'b0;
  // Watchdog compiled out: low for every legal TIMEOUT.
  assign stall     = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      order_err_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      order_err_q <= order_err_d;
      err_q       <= err_q | order_err_d | stall_set;
    end
  end

  assign period_len = period_q;
  assign high_len   = high_q;
  assign meas_valid = mv_q;
  assign order_err  = order_err_q;
  assign err_sticky = err_q;

endmodule
